// File: rtl/point_kinetics_engine.sv
// Point-kinetics flux integrator: one timestep = rod/precursor sums, delayed-neutron add, chunked prompt term.
// Optional clamped arithmetic with sticky flag: define PKM_SATURATION_EN.
module point_kinetics_engine #(
    parameter int N_RODS                = 6,
    parameter int N_GROUPS              = 6,
    parameter int RX_WIDTH              = 16,
    parameter int PREC_WIDTH            = 64,
    parameter int FLUX_WIDTH            = 51,
    parameter int LOG2_STEPS_PER_SECOND = 14,
    parameter int CRITICAL_OFFSET       = 4050,
    parameter logic [FLUX_WIDTH-1:0] RESET_FLUX = FLUX_WIDTH'(1) << 47
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           new_timestep,
    input  logic [N_RODS*RX_WIDTH-1:0]     rod_reactivity,
    input  logic [N_GROUPS*PREC_WIDTH-1:0] precursor_neutron,
    output logic [FLUX_WIDTH-1:0]          neutron_flux,
    output logic                           busy,
    output logic                           step_done,
    output logic                           overrun,
    output logic                           saturated
);
    // state     | meaning
    // S_IDLE    | waiting for new_timestep, inputs captured on accept
    // S_SUM     | one rod word and one precursor word accumulated per cycle
    // S_DELAYED | delayed-neutron add, flux snapshot and rho latched
    // S_MUL     | |rho| times current 16-bit chunk of the scaled snapshot
    // S_APPLY   | product shifted into place and added/subtracted
    // S_DONE    | final flux visible, step_done pulse
    localparam int SUM_CYC  = (N_RODS > N_GROUPS) ? N_RODS : N_GROUPS;
    localparam int CW       = $clog2(SUM_CYC + 1);
    localparam int SC_W     = FLUX_WIDTH - 18;
    localparam int N_CHUNKS = (SC_W + 15) / 16;
    localparam int CH_W     = 16 * N_CHUNKS;
    localparam int KW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int RS_W     = RX_WIDTH + $clog2(N_RODS + 1) + 2;
    localparam int PSUM_W   = PREC_WIDTH + $clog2(N_GROUPS + 1);
    localparam int PROD_W   = RS_W + 16;
    localparam int SH_W     = PROD_W + CH_W;
    localparam int DW0      = (PSUM_W > SH_W) ? PSUM_W : SH_W;
    localparam int DW       = ((DW0 > FLUX_WIDTH) ? DW0 : FLUX_WIDTH) + 1;
    localparam logic [FLUX_WIDTH-1:0] FLUX_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_SUM, S_DELAYED, S_MUL, S_APPLY, S_DONE} state_t;

    state_t                         state, state_nxt;
    logic [CW-1:0]                  sum_cnt;
    logic [KW-1:0]                  chunk_cnt;
    logic [N_RODS*RX_WIDTH-1:0]     rod_sh;
    logic [N_GROUPS*PREC_WIDTH-1:0] prec_sh;
    logic [RS_W-1:0]                rod_sum;
    logic [PSUM_W-1:0]              prec_sum;
    logic [SC_W-1:0]                scaled_r;
    logic [RS_W-1:0]                rho_mag;
    logic                           rho_neg;
    logic [PROD_W-1:0]              product;
    logic [FLUX_WIDTH-1:0]          flux;
    logic                           overrun_r, saturated_r;

    logic [RS_W-1:0]       rho_full;
    logic [SC_W-1:0]       scaled_c;
    logic [CH_W-1:0]       scaled_pad;
    logic [15:0]           chunk_c;
    logic [DW-1:0]         addend;
    logic                  do_sub;
    logic [FLUX_WIDTH-1:0] flux_next;
    logic                  sat_hit;
`ifdef PKM_SATURATION_EN
    logic [DW-1:0]         sum_w;
`endif

    assign rho_full   = rod_sum - RS_W'(CRITICAL_OFFSET);
    assign scaled_c   = SC_W'(flux >> 18) + SC_W'(flux >> 19) + SC_W'(flux >> 21) + SC_W'(flux >> 22);
    assign scaled_pad = CH_W'(scaled_r);
    assign chunk_c    = 16'(scaled_pad >> {chunk_cnt, 4'b0000});

    always_comb begin
        addend = '0;
        do_sub = 1'b0;
        if (state == S_DELAYED) begin
            addend = DW'(prec_sum >> LOG2_STEPS_PER_SECOND);
        end else if (state == S_APPLY) begin
            addend = DW'(product) << {chunk_cnt, 4'b0000};
            do_sub = rho_neg;
        end
`ifdef PKM_SATURATION_EN
        sum_w = do_sub ? DW'(flux) - addend : DW'(flux) + addend;
        if (do_sub && (addend > DW'(flux))) begin
            flux_next = '0;
            sat_hit   = 1'b1;
        end else if (!do_sub && (sum_w > DW'(FLUX_MAX))) begin
            flux_next = FLUX_MAX;
            sat_hit   = 1'b1;
        end else begin
            flux_next = sum_w[FLUX_WIDTH-1:0];
            sat_hit   = 1'b0;
        end
`else
        flux_next = do_sub ? FLUX_WIDTH'(DW'(flux) - addend) : FLUX_WIDTH'(DW'(flux) + addend);
        sat_hit   = 1'b0;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            flux        <= RESET_FLUX;
            overrun_r   <= 1'b0;
            saturated_r <= 1'b0;
            sum_cnt     <= '0;
            chunk_cnt   <= '0;
            rod_sh      <= '0;
            prec_sh     <= '0;
            rod_sum     <= '0;
            prec_sum    <= '0;
            scaled_r    <= '0;
            rho_mag     <= '0;
            rho_neg     <= 1'b0;
            product     <= '0;
        end else begin
            state <= state_nxt;
            if (new_timestep && (state != S_IDLE))
                overrun_r <= 1'b1;
            if (((state == S_DELAYED) || (state == S_APPLY)) && sat_hit)
                saturated_r <= 1'b1;
            case (state)
                S_IDLE: if (new_timestep) begin
                    rod_sh   <= rod_reactivity;
                    prec_sh  <= precursor_neutron;
                    rod_sum  <= '0;
                    prec_sum <= '0;
                    sum_cnt  <= CW'(SUM_CYC - 1);
                end
                S_SUM: begin
                    // shifting the captured words down feeds zeros once a short list runs out
                    rod_sum  <= rod_sum + RS_W'(rod_sh[RX_WIDTH-1:0]);
                    prec_sum <= prec_sum + PSUM_W'(prec_sh[PREC_WIDTH-1:0]);
                    rod_sh   <= rod_sh >> RX_WIDTH;
                    prec_sh  <= prec_sh >> PREC_WIDTH;
                    sum_cnt  <= sum_cnt - 1'b1;
                end
                S_DELAYED: begin
                    flux      <= flux_next;
                    scaled_r  <= scaled_c;
                    rho_neg   <= rho_full[RS_W-1];
                    rho_mag   <= rho_full[RS_W-1] ? RS_W'(-rho_full) : rho_full;
                    chunk_cnt <= KW'(N_CHUNKS - 1);
                end
                S_MUL: product <= PROD_W'(rho_mag) * PROD_W'(chunk_c);
                S_APPLY: begin
                    flux <= flux_next;
                    if (chunk_cnt != '0)
                        chunk_cnt <= chunk_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (new_timestep) state_nxt = S_SUM;
            S_SUM:     if (sum_cnt == '0) state_nxt = S_DELAYED;
            S_DELAYED: state_nxt = S_MUL;
            S_MUL:     state_nxt = S_APPLY;
            S_APPLY:   state_nxt = (chunk_cnt == '0) ? S_DONE : S_MUL;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_SUM) || (state == S_DELAYED) || (state == S_MUL) || (state == S_APPLY);
        step_done = (state == S_DONE);
    end

    assign neutron_flux = flux;
    assign overrun      = overrun_r;
    assign saturated    = saturated_r;

endmodule

// File: tb/tb_point_kinetics_engine.sv
// Bench for point_kinetics_engine at default parameters: vector table, randomized steps vs model, corner sequences.
module tb_point_kinetics_engine;
    localparam int LAT = 14;
    localparam logic [50:0] RF = 51'(64'd1 << 47);
    localparam logic [50:0] FMAX = '1;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         new_timestep;
    logic [95:0]  rod_reactivity;
    logic [383:0] precursor_neutron;
    logic [50:0]  neutron_flux;
    logic         busy, step_done, overrun, saturated;

    int total = 0;
    int bad = 0;
    logic [50:0] mflux;
    bit msat;

    point_kinetics_engine dut (
        .clk_in(clk_in), .rst_in(rst_in), .new_timestep(new_timestep),
        .rod_reactivity(rod_reactivity), .precursor_neutron(precursor_neutron),
        .neutron_flux(neutron_flux), .busy(busy), .step_done(step_done),
        .overrun(overrun), .saturated(saturated)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [95:0]  rods;
        logic [383:0] precs;
        logic [50:0]  exp_flux;
    } vec_t;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One timestep from the rules: delayed add, then prompt term from the pre-add flux.
    function automatic logic [50:0] model_step(input logic [50:0] f, input logic [95:0] rods,
                                               input logic [383:0] precs, output bit sat_out);
        longint rsum = 0;
        longint rho;
        logic [127:0] psum = 0;
        logic [127:0] big, scaled, mag, term;
        logic [50:0] f1;
        sat_out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rsum += longint'(rods[i*16 +: 16]);
            psum += 128'(precs[i*64 +: 64]);
        end
        big = 128'(f) + (psum >> 14);
`ifdef PKM_SATURATION_EN
        if (big > 128'(FMAX)) begin f1 = FMAX; sat_out = 1'b1; end
        else f1 = big[50:0];
`else
        f1 = big[50:0];
`endif
        rho = rsum - 4050;
        mag = 128'(rho < 0 ? -rho : rho);
        scaled = ((128'(f) >> 18) + (128'(f) >> 19) + (128'(f) >> 21) + (128'(f) >> 22)) & ((128'(1) << 33) - 1);
`ifdef PKM_SATURATION_EN
        for (int k = 2; k >= 0; k--) begin
            term = (mag * ((scaled >> (16 * k)) & 128'hffff)) << (16 * k);
            if (rho < 0) begin
                if (term > 128'(f1)) begin f1 = '0; sat_out = 1'b1; end
                else f1 = f1 - term[50:0];
            end else begin
                if (128'(f1) + term > 128'(FMAX)) begin f1 = FMAX; sat_out = 1'b1; end
                else f1 = f1 + term[50:0];
            end
        end
`else
        term = mag * scaled;
        f1 = (rho < 0) ? f1 - term[50:0] : f1 + term[50:0];
`endif
        return f1;
    endfunction

    task automatic do_reset();
        rst_in = 1'b1;
        new_timestep = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        mflux = RF;
        msat = 1'b0;
    endtask

    task automatic do_step(input logic [95:0] rods, input logic [383:0] precs, input string name);
        int cyc;
        bit s;
        mflux = model_step(mflux, rods, precs, s);
        msat |= s;
        rod_reactivity = rods;
        precursor_neutron = precs;
        new_timestep = 1'b1;
        tick();
        new_timestep = 1'b0;
        rod_reactivity = {3{$urandom}};
        precursor_neutron = {12{$urandom}};
        check({name, " busy_after_accept"}, 64'(busy), 64'd1);
        cyc = 1;
        while (!step_done && cyc < 100) begin
            tick();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(LAT));
        check({name, " flux"}, 64'(neutron_flux), 64'(mflux));
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        tick();
        check({name, " done_one_cycle"}, 64'(step_done), 64'd0);
    endtask

    initial begin
        vec_t vt[7];
        logic [95:0] rr;
        logic [383:0] pp;
        int pulses;

        rst_in = 1'b1;
        new_timestep = 1'b0;
        rod_reactivity = '0;
        precursor_neutron = '0;

        vt[0] = '{96'(4050), '0, RF};
        vt[1] = '{96'(4000) | (96'(150) << 16), '0, RF + 51'd90596966400};
        vt[2] = '{96'(2025) | (96'(2025) << 80), 384'(1) << 20, RF + 51'd64};
        vt[3] = '{96'(3950), '0, RF - 51'd90596966400};
        vt[4] = '{96'(4050), (384'(16384000) << 320) | (384'(16384) << 128), RF + 51'd1001};
        vt[5] = '{96'(4051), 384'(1) << 20, RF + 51'd64 + 51'd905969664};
`ifdef PKM_SATURATION_EN
        vt[6] = '{96'(4050), '1, FMAX};
`else
        vt[6] = '{96'(4050), '1, RF - 51'd1};
`endif

        do_reset();
        check("reset flux", 64'(neutron_flux), 64'(RF));
        check("reset busy", 64'(busy), 64'd0);
        check("reset step_done", 64'(step_done), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);
        check("reset saturated", 64'(saturated), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            do_step(vt[i].rods, vt[i].precs, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table_flux", i), 64'(neutron_flux), 64'(vt[i].exp_flux));
            check($sformatf("vec%0d saturated", i), 64'(saturated), 64'(msat));
        end

        do_reset();
        for (int n = 0; n < 24; n++) begin
            rr = '0;
            pp = '0;
            for (int r = 0; r < 6; r++)
                rr[r*16 +: 16] = (n % 6 == 5) ? 16'd0 : 16'($urandom_range(0, 1400));
            for (int g = 0; g < 6; g++)
                pp[g*64 +: 64] = {$urandom, $urandom} >> $urandom_range(8, 63);
            do_step(rr, pp, $sformatf("rnd%0d", n));
        end
        check("rnd saturated", 64'(saturated), 64'(msat));
        check("rnd overrun", 64'(overrun), 64'd0);

        // second request three cycles into a step
        do_reset();
        mflux = model_step(mflux, 96'(4100), '0, msat);
        rod_reactivity = 96'(4100);
        precursor_neutron = '0;
        new_timestep = 1'b1;
        tick();
        new_timestep = 1'b0;
        tick();
        tick();
        check("ovr before", 64'(overrun), 64'd0);
        rod_reactivity = 96'(9000);
        new_timestep = 1'b1;
        tick();
        new_timestep = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (step_done) pulses++;
            tick();
        end
        check("ovr pulses", 64'(pulses), 64'd1);
        check("ovr flag", 64'(overrun), 64'd1);
        check("ovr flux", 64'(neutron_flux), 64'(mflux));
        check("ovr idle", 64'(busy), 64'd0);

        // reset while in APPLY, with a request on the same cycle
        do_reset();
        rod_reactivity = 96'(4200);
        precursor_neutron = 384'(1) << 30;
        new_timestep = 1'b1;
        tick();
        new_timestep = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("rst_apply busy", 64'(busy), 64'd1);
        check("rst_apply flux_moved", 64'(neutron_flux != RF), 64'd1);
        rst_in = 1'b1;
        new_timestep = 1'b1;
        tick();
        rst_in = 1'b0;
        new_timestep = 1'b0;
        check("rst_apply flux", 64'(neutron_flux), 64'(RF));
        check("rst_apply busy_low", 64'(busy), 64'd0);
        check("rst_apply no_done", 64'(step_done), 64'd0);
        check("rst_apply overrun", 64'(overrun), 64'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (step_done || busy) pulses++;
            tick();
        end
        check("rst_apply quiet", 64'(pulses), 64'd0);
        check("rst_apply flux_hold", 64'(neutron_flux), 64'(RF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
